jk_cmd_sequencer: RTL and testbench

Upstream driver for the JK flip-flop stage. It accepts JK commands (hold/reset/set/toggle, each with a repeat length) over a valid/ready interface and buffers them in a small FIFO. It then drives registered J/K onto the flip-flop for the commanded number of cycles. It also runs a reference model of the flip-flop and flags any divergence from the flip-flop's fed-back Q1.

---
 rtl/jk_seq_pkg.sv | 13 +
 rtl/jk_cmd_fifo.sv | 33 +++
 rtl/jk_cmd_sequencer.sv | 67 ++++++
 tb/tb_jk_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared op encodings, FSM states and command layout for the JK command sequencer.
package jk_seq_pkg;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;
    localparam int CMD_LEN_W = 4;
    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_e;
    typedef struct packed {
        logic [1:0]           op;
        logic [CMD_LEN_W-1:0] len;
    } cmd_t;
endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous FIFO with wrap-bit pointers; refuses pushes while full.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign empty = wp == rp;
    assign rdata = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers JK commands and drives registered J/K for len+1 cycles each,
// while a reference JK model checks the fed-back flip-flop output.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             q_fb,
    input  logic             mism_clr,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             cmd_done,
    output logic             exp_q,
    output logic             mismatch
);
    state_e           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W+1:0] head;
    logic             full, empty, pop;
    assign cmd_ready = !full;
    // Pop from IDLE, or on the last drive cycle so commands run without a bubble.
    assign pop       = !empty && (state == IDLE || cnt == '0);
    assign cmd_done  = state == DRIVE && cnt == '0;
    assign busy      = state == DRIVE || !empty;
    jk_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(LEN_W + 2)) u_fifo (
        .clk  (CLK),
        .rst_n(RST_n),
        .push (cmd_valid),
        .pop  (pop),
        .wdata({cmd_op, cmd_len}),
        .rdata(head),
        .full (full),
        .empty(empty)
    );
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cnt      <= '0;
            {J, K}   <= OP_HOLD;
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            exp_q    <= (J & ~exp_q) | (~K & exp_q);
            mismatch <= (q_fb != exp_q) || (mismatch && !mism_clr);
            if (pop) begin
                {J, K} <= head[LEN_W+:2];
                cnt    <= head[LEN_W-1:0];
                state  <= DRIVE;
            end else if (state == DRIVE) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    state  <= IDLE;
                    {J, K} <= OP_HOLD;
                end
            end
        end
    end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: queue-based reference model with per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;
    logic       CLK = 0, RST_n = 0, cmd_valid = 0, mism_clr = 0, fault = 0;
    logic [1:0] cmd_op = 0;
    logic [3:0] cmd_len = 0;
    logic       cmd_ready, J, K, busy, cmd_done, exp_q, mismatch, q_fb, ff_q;
    int         n_cmp = 0, n_bad = 0;
    logic       cmp_on = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(4)) dut (
        .CLK(CLK), .RST_n(RST_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .q_fb(q_fb), .mism_clr(mism_clr),
        .J(J), .K(K), .busy(busy), .cmd_done(cmd_done), .exp_q(exp_q), .mismatch(mismatch)
    );

    always #5 CLK = ~CLK;

    // Behavioural JK flip-flop driven by the DUT; fault forces its feedback low.
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ff_q <= 1'b0;
        else case ({J, K})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end
    assign q_fb = fault ? 1'b0 : ff_q;

    // Reference: pending queue plus remaining drive cycles of the active command.
    logic [5:0] mq[$];
    int         m_rem = 0;
    logic [1:0] m_op = 0, m_jk;
    logic       m_exp = 0, m_mis = 0, m_full;
    logic [5:0] m_c;
    assign m_jk = (m_rem > 0) ? m_op : 2'b00;
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            mq.delete();
            m_rem = 0;
            m_op  = 0;
            m_exp = 0;
            m_mis = 0;
        end else begin
            m_mis = (q_fb != m_exp) || (m_mis && !mism_clr);
            case (m_jk)
                2'b01:   m_exp = 1'b0;
                2'b10:   m_exp = 1'b1;
                2'b11:   m_exp = !m_exp;
                default: m_exp = m_exp;
            endcase
            m_full = mq.size() == DEPTH;
            if (m_rem > 1) m_rem = m_rem - 1;
            else if (mq.size() > 0) begin
                m_c   = mq.pop_front();
                m_op  = m_c[5:4];
                m_rem = int'(m_c[3:0]) + 1;
            end else m_rem = 0;
            if (cmd_valid && !m_full) mq.push_back({cmd_op, cmd_len});
        end
    end

    task automatic chk(input string nm, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("J", J, m_jk[1]);
            chk("K", K, m_jk[0]);
            chk("cmd_done", cmd_done, m_rem == 1);
            chk("busy", busy, m_rem > 0 || mq.size() > 0);
            chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
            chk("exp_q", exp_q, m_exp);
            chk("mismatch", mismatch, m_mis);
        end
    end

    // Per-cycle trace of {J,K,exp_q,cmd_done} for the directed window checks.
    logic       rec_on = 0;
    logic [3:0] rec[64];
    int         rec_n = 0;
    always @(negedge CLK) begin
        if (rec_on && rec_n < 64) begin
            rec[rec_n] = {J, K, exp_q, cmd_done};
            rec_n++;
        end
    end

    task automatic push(input logic [1:0] op, input logic [3:0] len);
        logic acc = 0;
        cmd_op = op;
        cmd_len = len;
        cmd_valid = 1;
        for (int i = 0; i < 200; i++) begin
            acc = cmd_ready;
            @(negedge CLK);
            if (acc) break;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: cmd_ready low for 200 cycles at %0t", $time);
        end
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge CLK);
        chk("idle_timeout", busy, 1'b0);
    endtask

    function automatic int first_set();
        for (int i = 0; i < rec_n; i++) if (rec[i][3:2] == 2'b10) return i;
        return -1;
    endfunction

    initial begin
        int f, nj, nd, last;
        logic [15:0] ops;
        logic [7:0]  seq, dn;
        logic        seen;
        repeat (3) @(negedge CLK);
        chk("rst_J", J, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        RST_n = 1;
        cmp_on = 1;
        @(negedge CLK);
        chk("idle_J", J, 1'b0);
        chk("idle_K", K, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", cmd_ready, 1'b1);
        chk("idle_mismatch", mismatch, 1'b0);

        // Single SET, len=2.
        rec_n = 0;
        rec_on = 1;
        push(2'b10, 4'd2);
        repeat (8) @(negedge CLK);
        rec_on = 0;
        nj = 0; nd = 0; last = -1;
        for (int i = 0; i < rec_n; i++) begin
            if (rec[i][3:2] == 2'b10) begin nj++; last = i; end
            if (rec[i][0]) nd++;
        end
        chk("set_window_is_3", nj == 3, 1'b1);
        chk("set_one_done", nd == 1, 1'b1);
        chk("set_done_last", last >= 0 && rec[last][0], 1'b1);
        chk("set_exp_q", exp_q, 1'b1);
        chk("set_ff_q", ff_q, 1'b1);
        chk("set_mismatch", mismatch, 1'b0);

        // SET0, TOG3, RST0, HOLD1 back-to-back.
        ops = {2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
        seq = 8'b10101000;
        dn  = 8'b10001101;
        rec_n = 0;
        rec_on = 1;
        push(2'b10, 4'd0);
        push(2'b11, 4'd3);
        push(2'b01, 4'd0);
        push(2'b00, 4'd1);
        repeat (14) @(negedge CLK);
        rec_on = 0;
        f = first_set();
        chk("seq_found", f >= 0 && f + 9 <= rec_n, 1'b1);
        if (f >= 0 && f + 9 <= rec_n)
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("seq_jk%0d_J", i), rec[f+i][3], ops[15-2*i]);
                chk($sformatf("seq_jk%0d_K", i), rec[f+i][2], ops[14-2*i]);
                chk($sformatf("seq_done%0d", i), rec[f+i][0], dn[7-i]);
                chk($sformatf("seq_exp%0d", i), rec[f+1+i][1], seq[7-i]);
            end
        chk("seq_mismatch", mismatch, 1'b0);
        wait_idle();

        // Fill while stalled on a long toggle.
        push(2'b11, 4'd15);
        push(2'b10, 4'd3);
        push(2'b00, 4'd0);
        push(2'b01, 4'd0);
        push(2'b00, 4'd0);
        chk("fill_ready_low", cmd_ready, 1'b0);
        push(2'b11, 4'd0);
        chk("fill_5th_after_pop_J", J, 1'b1);
        chk("fill_5th_after_pop_K", K, 1'b0);
        wait_idle();

        // Fault injection and clear.
        push(2'b10, 4'd0);
        wait_idle();
        chk("fault_pre_exp", exp_q, 1'b1);
        fault = 1;
        @(negedge CLK);
        chk("fault_set", mismatch, 1'b1);
        repeat (3) @(negedge CLK);
        chk("fault_sticky", mismatch, 1'b1);
        mism_clr = 1;
        @(negedge CLK);
        chk("fault_set_wins", mismatch, 1'b1);
        fault = 0;
        @(negedge CLK);
        mism_clr = 0;
        chk("fault_cleared", mismatch, 1'b0);

        // Reset in the middle of a toggle with two queued.
        push(2'b11, 4'd10);
        push(2'b10, 4'd1);
        push(2'b01, 4'd1);
        nj = 0;
        for (int i = 0; i < 50 && nj < 4; i++) begin
            if (J && K) nj++;
            if (nj < 4) @(negedge CLK);
        end
        chk("mid_tog_reached", nj == 4, 1'b1);
        #2 RST_n = 0;
        #1;
        chk("mid_rst_J", J, 1'b0);
        chk("mid_rst_K", K, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", cmd_done, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        @(negedge CLK);
        RST_n = 1;
        seen = 0;
        repeat (6) begin
            @(negedge CLK);
            seen = seen | cmd_done | busy;
        end
        chk("post_rst_quiet", seen, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom % 3) == 0;
            cmd_op    = 2'($urandom);
            cmd_len   = ($urandom % 8 == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            mism_clr  = ($urandom % 10) == 0;
            fault     = ($urandom % 25) == 0;
            @(negedge CLK);
        end
        cmd_valid = 0;
        fault = 0;
        mism_clr = 0;
        wait_idle();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
